// File: rtl/riscv_muldiv_unit.sv
// RV M-extension execute unit: multi-cycle multiply and restoring divide behind valid/ready
// handshakes, with an optional DIV/REM result cache so the paired op completes in one cycle.
module riscv_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS    = 1,
  parameter int FUSE_DIVREM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int ITERS = XLEN / DIV_BITS;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            cache_valid_q, cache_valid_d, c_sgn_q, c_sgn_d;
  logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;

  // Multiplier operands come straight from the inputs when idle so a 1-cycle
  // multiply can complete on the accept edge; otherwise from the latched copy.
  logic [1:0]        mop;
  logic [XLEN-1:0]   ma, mb, mul_res;
  logic              ma_sgn, mb_sgn;
  logic [2*XLEN-1:0] ma_ext, mb_ext, prod;

  always_comb begin
    if (state_q == IDLE) begin
      ma = rs1; mb = rs2; mop = funct3[1:0];
    end else begin
      ma = a_q; mb = b_q; mop = op_q;
    end
    ma_sgn  = (mop == 2'b01) || (mop == 2'b10);
    mb_sgn  = (mop == 2'b01);
    ma_ext  = {{XLEN{ma_sgn & ma[XLEN-1]}}, ma};
    mb_ext  = {{XLEN{mb_sgn & mb[XLEN-1]}}, mb};
    prod    = ma_ext * mb_ext;
    mul_res = (mop == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  logic            in_sgn, div_zero, div_ovf, div_hit;
  logic [XLEN-1:0] dvd_mag, dvs_mag, imm_quo, imm_rem;

  always_comb begin
    in_sgn   = ~funct3[0];
    div_zero = (rs2 == '0);
    div_ovf  = in_sgn && (rs1 == INT_MIN) && (rs2 == '1);
    div_hit  = (FUSE_DIVREM != 0) && cache_valid_q && (c_a_q == rs1) &&
               (c_b_q == rs2) && (c_sgn_q == in_sgn);
    dvd_mag  = (in_sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    dvs_mag  = (in_sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    imm_quo  = div_zero ? '1  : (div_ovf ? rs1 : c_quo_q);
    imm_rem  = div_zero ? rs1 : (div_ovf ? '0  : c_rem_q);
  end

  logic [XLEN:0]   part;
  logic [XLEN-1:0] it_q, it_r;

  always_comb begin
    it_r = rem_q;
    it_q = quo_q;
    part = '0;
    for (int unsigned j = 0; j < DIV_BITS; j++) begin
      part = {it_r, it_q[XLEN-1]};
      it_q = {it_q[XLEN-2:0], 1'b0};
      if (part >= {1'b0, dvs_q}) begin
        part    = part - {1'b0, dvs_q};
        it_q[0] = 1'b1;
      end
      it_r = part[XLEN-1:0];
    end
  end

  logic            fx_sgn;
  logic [XLEN-1:0] fx_quo, fx_rem;

  always_comb begin
    fx_sgn = ~op_q[0];
    fx_quo = (fx_sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    fx_rem = (fx_sgn && a_q[XLEN-1]) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    dvs_d         = dvs_q;
    result_d      = result_q;
    cache_valid_d = cache_valid_q;
    c_a_d         = c_a_q;
    c_b_d         = c_b_q;
    c_sgn_d       = c_sgn_q;
    c_quo_d       = c_quo_q;
    c_rem_d       = c_rem_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d  = rs1;
        b_d  = rs2;
        op_d = funct3[1:0];
        if (!funct3[2]) begin
          cnt_d = CW'(1);
          if (MUL_LATENCY == 1) begin
            result_d = mul_res;
            state_d  = DONE;
          end else begin
            state_d  = MUL;
          end
        end else if (div_zero || div_ovf || div_hit) begin
          result_d      = funct3[1] ? imm_rem : imm_quo;
          cache_valid_d = 1'b1;
          c_a_d         = rs1;
          c_b_d         = rs2;
          c_sgn_d       = in_sgn;
          c_quo_d       = imm_quo;
          c_rem_d       = imm_rem;
          state_d       = DONE;
        end else begin
          // Magnitudes are loaded on the accept edge; DIV then runs ITERS steps plus fixup.
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      MUL: begin
        if (cnt_q == CW'(MUL_LATENCY - 1)) begin
          result_d = mul_res;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        if (cnt_q == CW'(ITERS)) begin
          result_d      = op_q[1] ? fx_rem : fx_quo;
          cache_valid_d = 1'b1;
          c_a_d         = a_q;
          c_b_d         = b_q;
          c_sgn_d       = fx_sgn;
          c_quo_d       = fx_quo;
          c_rem_d       = fx_rem;
          state_d       = DONE;
        end else begin
          quo_d = it_q;
          rem_d = it_r;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      result_q      <= '0;
      cache_valid_q <= 1'b0;
      c_a_q         <= '0;
      c_b_q         <= '0;
      c_sgn_q       <= 1'b0;
      c_quo_q       <= '0;
      c_rem_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      dvs_q         <= dvs_d;
      result_q      <= result_d;
      cache_valid_q <= cache_valid_d;
      c_a_q         <= c_a_d;
      c_b_q         <= c_b_d;
      c_sgn_q       <= c_sgn_d;
      c_quo_q       <= c_quo_d;
      c_rem_q       <= c_rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: a default 32-bit instance and a 16-bit/radix-4/1-cycle-multiply
// instance, each checked against an arithmetic reference and a latency model.
module tb_riscv_muldiv_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [2:0]  a_funct3;
  logic [31:0] a_rs1, a_rs2, a_result;
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [2:0]  b_funct3;
  logic [15:0] b_rs1, b_rs2, b_result;

  riscv_muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS(1), .FUSE_DIVREM(1)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .funct3(a_funct3),
    .rs1(a_rs1), .rs2(a_rs2), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .busy(a_busy));

  riscv_muldiv_unit #(.XLEN(16), .MUL_LATENCY(1), .DIV_BITS(2), .FUSE_DIVREM(1)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .funct3(b_funct3),
    .rs1(b_rs1), .rs2(b_rs2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .busy(b_busy));

  typedef struct { logic [63:0] res; int lat; } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic        cv_a = 1'b0, cs_a = 1'b0, cv_b = 1'b0, cs_b = 1'b0;
  logic [63:0] ca_a = '0, cb_a = '0, ca_b = '0, cb_b = '0;

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] ref_model(input int w, input logic [2:0] f3,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, pu;
    longint sa, sb, ua, ub, p;
    m  = mask(w);
    sa = a[w-1] ? longint'(a | ~m) : longint'(a);
    sb = b[w-1] ? longint'(b | ~m) : longint'(b);
    ua = longint'(a);
    ub = longint'(b);
    case (f3)
      3'd0: begin pu = a * b; return pu & m; end
      3'd1: begin p = sa * sb; pu = p; return (pu >> w) & m; end
      3'd2: begin p = sa * ub; pu = p; return (pu >> w) & m; end
      3'd3: begin pu = a * b; return (pu >> w) & m; end
      3'd4: begin if (b == 0) return m; p = sa / sb; pu = p; return pu & m; end
      3'd5: begin if (b == 0) return m; return (a / b) & m; end
      3'd6: begin if (b == 0) return a; p = sa % sb; pu = p; return pu & m; end
      default: begin if (b == 0) return a; pu = ua % ub; return pu & m; end
    endcase
  endfunction

  function automatic int exp_lat(input int w, input int iters, input int ml, input logic cv,
                                 input logic [63:0] ca, input logic [63:0] cb, input logic cs,
                                 input logic [2:0] f3, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m, mn;
    logic sgn;
    m   = mask(w);
    mn  = 64'd1 << (w - 1);
    sgn = ~f3[0];
    if (!f3[2]) return ml;
    if (y == 0) return 1;
    if (sgn && x == mn && y == m) return 1;
    if (cv && ca == x && cb == y && cs == sgn) return 1;
    return iters + 2;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = mask(w);
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'($urandom_range(1, 9));
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic run_a(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] er, input int el, input int hold);
    exp_t e, g;
    int lat, waitc;
    @(negedge clk);
    waitc = 0;
    while (!a_in_ready && waitc < 100) begin @(negedge clk); waitc++; end
    n_checks++;
    if (a_in_ready !== 1'b1) $display("FAIL a_idle_wait: in_ready=%b required 1", a_in_ready);
    else n_pass++;
    a_funct3 = f3; a_rs1 = x; a_rs2 = y; a_in_valid = 1'b1;
    e.res = er; e.lat = el;
    sb_a.push_back(e);
    if (f3[2]) begin cv_a = 1'b1; ca_a = {32'b0, x}; cb_a = {32'b0, y}; cs_a = ~f3[0]; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    g = sb_a.pop_front();
    n_checks++;
    if (a_result !== g.res[31:0])
      $display("FAIL a_result f3=%0d rs1=%h rs2=%h: got %h expected %h", f3, x, y, a_result, g.res[31:0]);
    else n_pass++;
    n_checks++;
    if (lat !== g.lat)
      $display("FAIL a_latency f3=%0d rs1=%h rs2=%h: got %0d expected %0d", f3, x, y, lat, g.lat);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_result !== g.res[31:0] || a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
        $display("FAIL a_hold cycle %0d: result=%h in_ready=%b out_valid=%b expected %h/0/1",
                 i, a_result, a_in_ready, a_out_valid, g.res[31:0]);
      else n_pass++;
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL a_release: out_valid=%b in_ready=%b expected 0/1", a_out_valid, a_in_ready);
    else n_pass++;
  endtask

  task automatic run_b(input logic [2:0] f3, input logic [15:0] x, input logic [15:0] y,
                       input logic [63:0] er, input int el);
    exp_t e, g;
    int lat, waitc;
    @(negedge clk);
    waitc = 0;
    while (!b_in_ready && waitc < 100) begin @(negedge clk); waitc++; end
    b_funct3 = f3; b_rs1 = x; b_rs2 = y; b_in_valid = 1'b1;
    e.res = er; e.lat = el;
    sb_b.push_back(e);
    if (f3[2]) begin cv_b = 1'b1; ca_b = {48'b0, x}; cb_b = {48'b0, y}; cs_b = ~f3[0]; end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    g = sb_b.pop_front();
    n_checks++;
    if (b_result !== g.res[15:0])
      $display("FAIL b_result f3=%0d rs1=%h rs2=%h: got %h expected %h", f3, x, y, b_result, g.res[15:0]);
    else n_pass++;
    n_checks++;
    if (lat !== g.lat)
      $display("FAIL b_latency f3=%0d rs1=%h rs2=%h: got %0d expected %0d", f3, x, y, lat, g.lat);
    else n_pass++;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_funct3 = '0; a_rs1 = '0; a_rs2 = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_funct3 = '0; b_rs1 = '0; b_rs2 = '0;
    #12;
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_result !== 32'h0)
      $display("FAIL reset_a: in_ready=%b out_valid=%b busy=%b result=%h expected 1/0/0/0",
               a_in_ready, a_out_valid, a_busy, a_result);
    else n_pass++;
    n_checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_result !== 16'h0)
      $display("FAIL reset_b: in_ready=%b out_valid=%b busy=%b result=%h expected 1/0/0/0",
               b_in_ready, b_out_valid, b_busy, b_result);
    else n_pass++;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_mul;
    run_a(3'b000, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFEB, 2, 0);
    run_a(3'b001, 32'h80000000, 32'h80000000, 64'h40000000, 2, 0);
    run_a(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF, 2, 0);
    run_a(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE, 2, 0);
  endtask

  task automatic test_div_fusion;
    run_a(3'b100, 32'hFFFFFFEC, 32'd3,        64'hFFFFFFFA, 34, 0);
    run_a(3'b110, 32'hFFFFFFEC, 32'd3,        64'hFFFFFFFE, 1,  0);
    run_a(3'b111, 32'hFFFFFFEC, 32'd3,        64'h00000002, 34, 0);
    run_a(3'b110, 32'd100,      32'hFFFFFFF9, 64'h00000002, 34, 0);
    run_a(3'b100, 32'd100,      32'hFFFFFFF9, 64'hFFFFFFF2, 1,  0);
  endtask

  task automatic test_div_special;
    run_a(3'b101, 32'd100,      32'd0,        64'hFFFFFFFF, 1, 0);
    run_a(3'b111, 32'd100,      32'd0,        64'd100,      1, 0);
    run_a(3'b100, 32'hFFFFFFFB, 32'd0,        64'hFFFFFFFF, 1, 0);
    run_a(3'b110, 32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB, 1, 0);
    run_a(3'b100, 32'h80000000, 32'hFFFFFFFF, 64'h80000000, 1, 0);
    run_a(3'b110, 32'h80000000, 32'hFFFFFFFF, 64'h00000000, 1, 0);
  endtask

  task automatic test_backpressure;
    run_a(3'b000, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFEB, 2, 5);
  endtask

  task automatic test_back_to_back;
    exp_t e, g;
    int lat;
    @(negedge clk);
    a_funct3 = 3'b000; a_rs1 = 32'd3; a_rs2 = 32'd5; a_in_valid = 1'b1;
    e.res = 64'd15; e.lat = 2;
    sb_a.push_back(e);
    @(posedge clk); #1;
    a_rs1 = 32'h10; a_rs2 = 32'h20;
    e.res = 64'h200; e.lat = 2;
    sb_a.push_back(e);
    for (int k = 0; k < 2; k++) begin
      lat = 1;
      while (!a_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      g = sb_a.pop_front();
      n_checks++;
      if (a_result !== g.res[31:0] || lat !== g.lat)
        $display("FAIL b2b_op%0d: result=%h latency=%0d expected %h/%0d", k, a_result, lat, g.res[31:0], g.lat);
      else n_pass++;
      n_checks++;
      if (a_in_ready !== 1'b0)
        $display("FAIL b2b_busy_ignore%0d: in_ready=%b expected 0", k, a_in_ready);
      else n_pass++;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      n_checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
        $display("FAIL b2b_release%0d: out_valid=%b in_ready=%b expected 0/1", k, a_out_valid, a_in_ready);
      else n_pass++;
      if (k == 0) begin
        @(posedge clk); #1;
        a_in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_div;
    run_a(3'b100, 32'd1000, 32'd7, 64'd142, 34, 0);
    @(negedge clk);
    a_funct3 = 3'b101; a_rs1 = 32'd50; a_rs2 = 32'd3; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (a_busy !== 1'b1 || a_out_valid !== 1'b0)
      $display("FAIL mid_div_busy: busy=%b out_valid=%b expected 1/0", a_busy, a_out_valid);
    else n_pass++;
    a_rst = 1'b1;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_result !== 32'h0)
      $display("FAIL mid_div_reset: out_valid=%b busy=%b in_ready=%b result=%h expected 0/0/1/0",
               a_out_valid, a_busy, a_in_ready, a_result);
    else n_pass++;
    cv_a = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    run_a(3'b110, 32'd1000, 32'd7, 64'd6, 34, 0);
  endtask

  task automatic test_random_a(input int n);
    logic [31:0] x, y;
    logic [2:0]  f3;
    x = '0; y = '0;
    for (int i = 0; i < n; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if (i == 0 || $urandom_range(0, 2) != 0) begin x = pick(32)[31:0]; y = pick(32)[31:0]; end
      run_a(f3, x, y, ref_model(32, f3, {32'b0, x}, {32'b0, y}),
            exp_lat(32, 32, 2, cv_a, ca_a, cb_a, cs_a, f3, {32'b0, x}, {32'b0, y}), 0);
    end
  endtask

  task automatic test_narrow;
    run_b(3'b100, 16'd100,   16'd7,    64'd14,    10);
    run_b(3'b100, 16'h8000,  16'hFFFF, 64'h8000,  1);
    run_b(3'b110, 16'h8000,  16'hFFFF, 64'h0000,  1);
    run_b(3'b011, 16'hFFFF,  16'hFFFF, 64'hFFFE,  1);
    run_b(3'b000, 16'h0100,  16'h0100, 64'h0000,  1);
    run_b(3'b110, 16'd100,   16'd7,    64'd2,     10);
  endtask

  task automatic test_random_b(input int n);
    logic [15:0] x, y;
    logic [2:0]  f3;
    x = '0; y = '0;
    for (int i = 0; i < n; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if (i == 0 || $urandom_range(0, 2) != 0) begin x = pick(16)[15:0]; y = pick(16)[15:0]; end
      run_b(f3, x, y, ref_model(16, f3, {48'b0, x}, {48'b0, y}),
            exp_lat(16, 8, 1, cv_b, ca_b, cb_b, cs_b, f3, {48'b0, x}, {48'b0, y}));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div_fusion();
    test_div_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    test_random_a(150);
    test_narrow();
    test_random_b(1000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
